// File: rtl/count_sequencer_if.sv
// Button, counter-digit and sequencer-output bundle for count_sequencer.
// master: the side that drives buttons and digits (board/testbench).
// slave:  the sequencer itself.
interface count_sequencer_if;
  logic       start_btn;
  logic       stop_btn;
  logic       clr_btn;
  logic [3:0] Qdata3;
  logic [3:0] Qdata2;
  logic [3:0] Qdata1;
  logic [3:0] Qdata0;
  logic       ena0in;
  logic       clr_cnt;
  logic       running;
  logic       done;
  logic [1:0] state;

  modport master (
    output start_btn, stop_btn, clr_btn, Qdata3, Qdata2, Qdata1, Qdata0,
    input  ena0in, clr_cnt, running, done, state
  );

  modport slave (
    input  start_btn, stop_btn, clr_btn, Qdata3, Qdata2, Qdata1, Qdata0,
    output ena0in, clr_cnt, running, done, state
  );
endinterface

// File: rtl/count_sequencer.sv
// Count sequencer: start/stop/clear control and prescaled count tick for a
// 4-digit BCD counter chain.
// Optional feature: define AUTO_RESTART_EN to restart counting (clr_cnt pulse,
// stay in RUN) when the terminal value is reached; otherwise the sequencer
// parks in DONE.
module count_sequencer #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter logic [3:0]  TERM3    = 4'd9,
  parameter logic [3:0]  TERM2    = 4'd6,
  parameter logic [3:0]  TERM1    = 4'd7,
  parameter logic [3:0]  TERM0    = 4'd4
) (
  input logic               clk,
  input logic               rst,
  count_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam logic [25:0] PreMax = 26'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [25:0] pre_q, pre_d;
  logic        ena0in_q, ena0in_d;
  logic        clr_cnt_q, clr_cnt_d;
  logic        running_q, running_d;
  logic        done_q, done_d;

  // Button history; armed_q masks events on the first edge after reset so a
  // button already held at release does not count as a press.
  logic        armed_q;
  logic        start_prev_q, stop_prev_q, clr_prev_q;

  logic        start_ev, stop_ev, clr_ev;
  logic        tick, at_term;

  assign start_ev = armed_q & bus.start_btn & ~start_prev_q;
  assign stop_ev  = armed_q & bus.stop_btn  & ~stop_prev_q;
  assign clr_ev   = armed_q & bus.clr_btn   & ~clr_prev_q;

  assign tick    = (state_q == StRun) && (pre_q == PreMax);
  assign at_term = ({bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0} ==
                    {TERM3, TERM2, TERM1, TERM0});

  // Next-state, prescaler and pulse outputs; events prioritised clr > stop > start.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    ena0in_d  = 1'b0;
    clr_cnt_d = 1'b0;

    if (clr_ev) begin
      state_d   = StIdle;
      pre_d     = '0;
      clr_cnt_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          pre_d = '0;
          if (!stop_ev && start_ev) state_d = StRun;
        end
        StRun: begin
          if (stop_ev) begin
            // Prescaler holds, so a stop on the tick cycle replays the tick on resume.
            state_d = StPause;
          end else if (tick) begin
            pre_d = '0;
            if (at_term) begin
`ifdef AUTO_RESTART_EN
              clr_cnt_d = 1'b1;
`else
              state_d   = StDone;
`endif
            end else begin
              ena0in_d = 1'b1;
            end
          end else begin
            pre_d = pre_q + 26'd1;
          end
        end
        StPause: begin
          if (!stop_ev && start_ev) state_d = StRun;
        end
        StDone: begin
          pre_d = '0;
          if (!stop_ev && start_ev) begin
            state_d   = StRun;
            clr_cnt_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);
    done_d    = (state_d == StDone);
  end

  // State, prescaler, button history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      ena0in_q     <= 1'b0;
      clr_cnt_q    <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      clr_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      ena0in_q     <= ena0in_d;
      clr_cnt_q    <= clr_cnt_d;
      running_q    <= running_d;
      done_q       <= done_d;
      armed_q      <= 1'b1;
      start_prev_q <= bus.start_btn;
      stop_prev_q  <= bus.stop_btn;
      clr_prev_q   <= bus.clr_btn;
    end
  end

  assign bus.state   = state_q;
  assign bus.ena0in  = ena0in_q;
  assign bus.clr_cnt = clr_cnt_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus pushes the expected output
// vector {ena0in, clr_cnt, running, done, state[1:0]} and the cycle at which it
// must appear; the monitor pops an entry whenever the observed vector changes.
module tb_count_sequencer;
  localparam int unsigned Presc = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  count_sequencer_if bus ();

  count_sequencer #(.PRESCALE(Presc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       req_strobe = 1'b0;
  int         req_code   = 0;
  logic [5:0] obs;

  assign obs = {bus.ena0in, bus.clr_cnt, bus.running, bus.done, bus.state};

  function automatic logic [5:0] mk(logic e, logic c, logic r, logic d, logic [1:0] s);
    return {e, c, r, d, s};
  endfunction

  localparam logic [5:0] VRun = 6'b001001;

  function automatic void push(int c, logic [5:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endfunction

  function automatic void pulse(int c);
    push(c, mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b01));
    push(c + 1, VRun);
  endfunction

  // Monitor: all comparisons live here so one process owns the counters.
  initial begin : monitor
    logic [5:0] last;
    exp_t       e;
    last = 6'b0;
    forever begin
      @(negedge clk or posedge req_strobe);
      if (req_strobe && clk) begin
        n_checks++;
        if (req_code == 1) begin
          if (obs !== 6'b0)
            $display("FAIL reset_outputs: got %b, want 000000", obs);
          if (obs !== 6'b0) n_fail++;
        end else begin
          if (exp_q.size() != 0)
            $display("FAIL leftover_expect: %0d entries unseen, first cyc %0d vec %b",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].vec);
          if (exp_q.size() != 0) n_fail++;
        end
      end else if (obs !== last) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change: cyc %0d got %b, was %b", cyc, obs, last);
          n_fail++;
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec !== obs) begin
            $display("FAIL output_change: got cyc %0d vec %b, want cyc %0d vec %b",
                     cyc, obs, e.cyc, e.vec);
            n_fail++;
          end
        end
        last = obs;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int n);
    while (cyc < n) step();
  endtask

  // m = {clr, stop, start}; levels high for one sampling edge.
  task automatic press(logic [2:0] m);
    bus.clr_btn   = m[2];
    bus.stop_btn  = m[1];
    bus.start_btn = m[0];
    step();
    bus.clr_btn   = 1'b0;
    bus.stop_btn  = 1'b0;
    bus.start_btn = 1'b0;
  endtask

  task automatic request(int code);
    req_code   = code;
    req_strobe = 1'b1;
    #1;
    req_strobe = 1'b0;
  endtask

  task automatic set_q(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    bus.Qdata3 = a;
    bus.Qdata2 = b;
    bus.Qdata1 = c;
    bus.Qdata0 = d;
  endtask

  initial begin : stimulus
    int s, p, r, e;
    bus.start_btn = 1'b1;  // held through reset release: must not start
    bus.stop_btn  = 1'b0;
    bus.clr_btn   = 1'b0;
    set_q(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) step();
    request(1);
    rst = 1'b0;
    wait_until(8);
    bus.start_btn = 1'b0;
    wait_until(10);
    press(3'b010);  // stop in IDLE: ignored

    // Start from IDLE, ticks every Presc cycles; start while running is ignored.
    wait_until(12);
    press(3'b001);
    s = cyc;
    push(s, VRun);
    wait_until(s + 1);
    press(3'b001);
    pulse(s + 4);
    pulse(s + 8);
    push(s + 12, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10));

    // Stop on the tick cycle: no ena0in, PAUSE; resume ticks at once.
    wait_until(s + 11);
    press(3'b010);
    p = cyc;
    wait_until(p + 10);
    press(3'b001);
    r = cyc;
    push(r, VRun);
    pulse(r + 1);
    pulse(r + 5);

    // Terminal value presented for the tick at r+9.
    wait_until(r + 6);
    set_q(4'd9, 4'd6, 4'd7, 4'd4);
`ifdef AUTO_RESTART_EN
    push(r + 9, mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
    push(r + 10, VRun);
    pulse(r + 13);
    pulse(r + 17);
    wait_until(r + 10);
    set_q(4'd0, 4'd0, 4'd0, 4'd0);
`else
    push(r + 9, mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b11));
    wait_until(r + 10);
    set_q(4'd0, 4'd0, 4'd0, 4'd0);
    wait_until(r + 12);
    press(3'b001);
    push(r + 13, mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
    push(r + 14, VRun);
    pulse(r + 17);
`endif

    // clr, stop and start together in RUN: clear wins.
    wait_until(r + 18);
    press(3'b111);
    push(r + 19, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
    push(r + 20, 6'b0);

    // Reset mid-RUN: outputs drop asynchronously with no clr_cnt pulse.
    wait_until(r + 22);
    press(3'b001);
    e = cyc;
    push(e, VRun);
    push(e + 2, 6'b0);
    wait_until(e + 2);
    #2;
    rst = 1'b1;
    #1;
    request(1);
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();

    request(2);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
